// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one memory request in flight
// and buffers returned words in a 2-entry queue that feeds the IF/ID register.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DROP = 2'd2
   } state_e;

   // Handshake: a request is live while imem_req_o=1 and imem_addr_o is held
   // constant until the cycle imem_ack_i=1; that cycle completes the transfer.
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] fifo_pc_q   [2];
   logic [31:0] fifo_pc_d   [2];
   logic [31:0] fifo_inst_q [2];
   logic [31:0] fifo_inst_d [2];

   logic       ack;
   logic       pop;
   logic       push;
   logic [1:0] count_nxt;
   logic [1:0] wr_idx;
   logic       credit;

   assign ack       = imem_ack_i & (state_q != S_IDLE);
   assign pop       = valid_o & ~stall_i & ~redirect_i;
   assign push      = ack & (state_q == S_BUSY) & ~redirect_i;
   assign count_nxt = count_q + {1'b0, push} - {1'b0, pop};
   assign wr_idx    = count_q - {1'b0, pop};
   assign credit    = (count_nxt < 2'd2);

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      pend_d         = pend_q;
      count_d        = count_nxt;
      fifo_pc_d[0]   = fifo_pc_q[0];
      fifo_pc_d[1]   = fifo_pc_q[1];
      fifo_inst_d[0] = fifo_inst_q[0];
      fifo_inst_d[1] = fifo_inst_q[1];

      if (pop) begin
         fifo_pc_d[0]   = fifo_pc_q[1];
         fifo_inst_d[0] = fifo_inst_q[1];
      end
      if (push) begin
         if (wr_idx[0]) begin
            fifo_pc_d[1]   = pc_q;
            fifo_inst_d[1] = imem_data_i;
         end else begin
            fifo_pc_d[0]   = pc_q;
            fifo_inst_d[0] = imem_data_i;
         end
      end

      if (redirect_i) begin
         // The queue is flushed, so there is always credit after a redirect.
         count_d = 2'd0;
         if ((state_q == S_IDLE) || ack) begin
            state_d = S_BUSY;
            pc_d    = redirect_pc_i;
         end else begin
            state_d = S_DROP;
            pend_d  = redirect_pc_i;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (credit) state_d = S_BUSY;
            end
            S_BUSY: begin
               if (ack) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = credit ? S_BUSY : S_IDLE;
               end
            end
            S_DROP: begin
               // Stale word is discarded; resume at the most recent target.
               if (ack) begin
                  pc_d    = pend_q;
                  state_d = credit ? S_BUSY : S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         pc_q           <= RESET_PC;
         pend_q         <= RESET_PC;
         count_q        <= 2'd0;
         fifo_pc_q[0]   <= 32'd0;
         fifo_pc_q[1]   <= 32'd0;
         fifo_inst_q[0] <= 32'd0;
         fifo_inst_q[1] <= 32'd0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         pend_q         <= pend_d;
         count_q        <= count_d;
         fifo_pc_q[0]   <= fifo_pc_d[0];
         fifo_pc_q[1]   <= fifo_pc_d[1];
         fifo_inst_q[0] <= fifo_inst_d[0];
         fifo_inst_q[1] <= fifo_inst_d[1];
      end
   end

   assign imem_req_o  = (state_q != S_IDLE);
   assign imem_addr_o = pc_q;
   assign valid_o     = (count_q != 2'd0);
   assign pc_o        = valid_o ? fifo_pc_q[0] : 32'd0;
   assign inst_o      = valid_o ? fifo_inst_q[0] : 32'd0;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl; instruction memory returns ~addr as the word.
module tb_fetch_ctrl;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   logic        clk_i;
   logic        rst_i;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic [1:0]  dbg_state_o;

   fetch_ctrl #(.RESET_PC(32'd0)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_data_i   (imem_data_i),
      .valid_o       (valid_o),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .dbg_state_o   (dbg_state_o)
   );

   assign imem_data_i = ~imem_addr_o;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        ack;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [1:0]  e_state;
   } vec_t;

   vec_t vq[$];
   int   n_vec;
   int   n_miss;

   task automatic add(input logic s, input logic r, input logic [31:0] rpc, input logic a,
                      input logic er, input logic [31:0] ea, input logic ev,
                      input logic [31:0] ep, input logic [1:0] es);
      vec_t v;
      v.stall = s; v.redir = r; v.rpc = rpc; v.ack = a;
      v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_state = es;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic er, input logic [31:0] ea,
                        input logic ev, input logic [31:0] ep, input logic [1:0] es);
      logic [31:0] ei;
      ei = ev ? ~ep : 32'd0;
      n_vec++;
      if (imem_req_o !== er || imem_addr_o !== ea || valid_o !== ev ||
          pc_o !== ep || inst_o !== ei || dbg_state_o !== es) begin
         n_miss++;
         $display("FAIL %s: got req=%b addr=%h valid=%b pc=%h inst=%h st=%0d, want req=%b addr=%h valid=%b pc=%h inst=%h st=%0d",
                  name, imem_req_o, imem_addr_o, valid_o, pc_o, inst_o, dbg_state_o,
                  er, ea, ev, ep, ei, es);
      end
   endtask

   initial begin
      n_vec = 0;
      n_miss = 0;
      rst_i = 1'b1;
      stall_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = 32'd0;
      imem_ack_i = 1'b0;

      // stall redir rpc ack | req addr valid pc state
      add(0,0,32'h0,0,        0,32'h0,       0,32'h0,  ST_IDLE); // v0 reset values
      add(0,0,32'h0,1,        1,32'h0,       0,32'h0,  ST_BUSY); // zero-wait stream
      add(0,0,32'h0,1,        1,32'h4,       1,32'h0,  ST_BUSY);
      add(0,0,32'h0,1,        1,32'h8,       1,32'h4,  ST_BUSY);
      add(0,0,32'h0,0,        1,32'hC,       1,32'h8,  ST_BUSY);
      add(1,0,32'h0,0,        1,32'hC,       0,32'h0,  ST_BUSY); // v5 stall, 3-cycle memory
      add(1,0,32'h0,0,        1,32'hC,       0,32'h0,  ST_BUSY);
      add(1,0,32'h0,1,        1,32'hC,       0,32'h0,  ST_BUSY);
      add(1,0,32'h0,0,        1,32'h10,      1,32'hC,  ST_BUSY);
      add(1,0,32'h0,0,        1,32'h10,      1,32'hC,  ST_BUSY);
      add(1,0,32'h0,1,        1,32'h10,      1,32'hC,  ST_BUSY);
      add(1,0,32'h0,0,        0,32'h14,      1,32'hC,  ST_IDLE); // v11 full, request drops
      add(0,0,32'h0,0,        0,32'h14,      1,32'hC,  ST_IDLE); // release stall
      add(0,0,32'h0,0,        1,32'h14,      1,32'h10, ST_BUSY);
      add(0,1,32'h100,0,      1,32'h14,      0,32'h0,  ST_BUSY); // v14 redirect, no ack
      add(0,0,32'h0,0,        1,32'h14,      0,32'h0,  ST_DROP);
      add(0,0,32'h0,1,        1,32'h14,      0,32'h0,  ST_DROP); // stale ack
      add(0,0,32'h0,1,        1,32'h100,     0,32'h0,  ST_BUSY);
      add(0,1,32'h40,1,       1,32'h104,     1,32'h100,ST_BUSY); // v18 redirect with ack
      add(0,1,32'h200,0,      1,32'h40,      0,32'h0,  ST_BUSY); // two redirects into DROP
      add(0,1,32'h300,0,      1,32'h40,      0,32'h0,  ST_DROP);
      add(0,0,32'h0,1,        1,32'h40,      0,32'h0,  ST_DROP);
      add(0,0,32'h0,1,        1,32'h300,     0,32'h0,  ST_BUSY);
      add(0,1,32'hFFFFFFFC,1, 1,32'h304,     1,32'h300,ST_BUSY); // v23 redirect to wrap point
      add(0,0,32'h0,1,        1,32'hFFFFFFFC,0,32'h0,  ST_BUSY);

      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < vq.size(); i++) begin
         check($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_valid,
               vq[i].e_pc, vq[i].e_state);
         stall_i       = vq[i].stall;
         redirect_i    = vq[i].redir;
         redirect_pc_i = vq[i].rpc;
         imem_ack_i    = vq[i].ack;
         @(negedge clk_i);
      end

      // PC wrapped to 0 after fetching 0xFFFFFFFC
      check("wrap", 1'b1, 32'h0, 1'b1, 32'hFFFFFFFC, ST_BUSY);
      stall_i = 1'b0;
      redirect_i = 1'b0;
      imem_ack_i = 1'b1;
      rst_i = 1'b1;
      #1;
      check("rst_async", 1'b0, 32'h0, 1'b0, 32'h0, ST_IDLE);
      @(posedge clk_i);
      #1;
      check("rst_held_ack", 1'b0, 32'h0, 1'b0, 32'h0, ST_IDLE);
      @(negedge clk_i);
      rst_i = 1'b0;
      imem_ack_i = 1'b0;
      check("rst_release", 1'b0, 32'h0, 1'b0, 32'h0, ST_IDLE);
      @(negedge clk_i);
      check("restart_req", 1'b1, 32'h0, 1'b0, 32'h0, ST_BUSY);
      imem_ack_i = 1'b1;
      @(negedge clk_i);
      check("restart_first", 1'b1, 32'h4, 1'b1, 32'h0, ST_BUSY);
      imem_ack_i = 1'b0;
      @(negedge clk_i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch controller that sequences the instruction-fetch front end against a variable-latency instruction memory. It owns the fetch PC, issues one outstanding memory request at a time, and buffers returned instructions in a 2-entry queue toward the IF/ID register. It honours downstream stalls and branch/jump redirects, and discards any stale response still in flight when a redirect arrives. It replaces the free-running PC adder/mux path in front of the IF/ID stage register.

## Interface
- RESET_PC, 32'd0, fetch address loaded on reset
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  asynchronous, active-high reset
- stall_i  input  1  consumer not accepting this cycle (hazard stall)
- redirect_i  input  1  taken branch or jump this cycle
- redirect_pc_i  input  32  new fetch address, valid with redirect_i
- imem_req_o  output  1  memory request
- imem_addr_o  output  32  request address, stable while imem_req_o=1
- imem_ack_i  input  1  response valid; sampled only while imem_req_o=1
- imem_data_i  input  32  instruction word, valid with imem_ack_i
- valid_o  output  1  queue head holds an instruction
- pc_o  output  32  address of head instruction (0 when empty)
- inst_o  output  32  head instruction word (0 when empty, i.e. bubble)

## Operation
- Registers:
  - fetch PC (drives imem_addr_o)
  - FSM state
  - 2-entry FIFO of {pc, inst} with 2-bit count
- Pop: valid_o & ~stall_i & ~redirect_i.
- Push: ack in BUSY & ~redirect_i. Pushes {imem_addr_o, imem_data_i}; fetch PC <= PC+4 (mod 2^32).
- Credit rule: a request is started or continued only if count_next < 2.
  - count_next = count + push − pop.
  - With one outstanding request, the FIFO can never overflow.
- States:
  - IDLE: imem_req_o=0. Goes to BUSY if count_next < 2.
  - BUSY: imem_req_o=1, addr = fetch PC.
    - On push: stays BUSY if count_next < 2, else goes to IDLE.
    - No ack: stays BUSY with address unchanged.
  - DROP: imem_req_o=1, addr = the stale address.
    - Waits for ack and discards the data.
    - On ack: goes to BUSY at the latched redirect PC, or to IDLE if no credit. After a redirect the FIFO is empty, so the next state is always BUSY.
- Redirect (highest priority, any state):
  - FIFO is cleared (count <= 0).
  - Redirect target is latched into the fetch PC, or into a pending-PC register while in DROP.
  - In IDLE: go to BUSY at redirect_pc_i.
  - In BUSY with no ack: go to DROP, keeping the old address on the bus until the ack.
  - In BUSY with ack in the same cycle: data discarded; go to BUSY at redirect_pc_i.
  - In DROP: the pending PC is overwritten by the newest target. Stay in DROP, or go to BUSY at the newest target if the ack arrives in the same cycle.
- stall_i only blocks the pop. It never drops a request or changes imem_addr_o.
- redirect_pc_i is not alignment-checked; it is used as-is.

## Timing
- Reset values (asynchronous):
  - state IDLE, count 0, fetch PC = RESET_PC
  - imem_req_o=0, imem_addr_o=RESET_PC
  - valid_o=0, pc_o=0, inst_o=0
- After reset deasserts:
  - imem_req_o rises on the first clock edge.
  - The first instruction is visible on valid_o one cycle after its ack.
- Zero-wait memory (ack in the same cycle as req) with no stalls: throughput is 1 instruction per cycle, steady state.
- Redirect latency: redirect sampled at edge N.
  - Request to target is on the bus during cycle N+1 if nothing is outstanding or the ack arrived in cycle N.
  - Otherwise it follows the stale ack by one cycle.
- The head instruction is visible the cycle after its push. Outputs come combinationally from the FIFO head register.
- Reset mid-request: all state clears immediately; a late ack is ignored because imem_req_o=0.

## Test plan
- **Reset/startup, zero-wait memory (ack=req), stall_i=0.**
  - Required: valid_o high from cycle 2 with pc_o 0,4,8,… on consecutive cycles.
  - Required: inst_o matches memory words.
- **Stall with 3-cycle memory latency.**
  - Stimulus: stall_i held high for 10 cycles.
  - Required: FIFO fills to 2 with pc 0 and 4; imem_req_o drops.
  - Required: pc_o stays 0 during the stall.
  - Required: on release, pc_o gives 0, then 4, then the request for 8 resumes.
- **Redirect with request outstanding.**
  - Stimulus: redirect_i with target 0x100 while a request to 0x10 is waiting.
  - Required: addr stays 0x10 until its ack; that data is never presented.
  - Required: the next request is 0x100; valid_o low in between.
- **Simultaneous redirect and ack.**
  - Required: ack data dropped; next cycle imem_addr_o=target, state BUSY.
- **Two redirects during DROP (0x200, then 0x300).**
  - Required: after the stale ack, the only fetch issued is 0x300.
- **Wrap-around and mid-operation reset.**
  - Stimulus: redirect to 0xFFFFFFFC.
  - Required: the next fetch is 0x00000000.
  - Stimulus: assert rst_i mid-BUSY.
  - Required: outputs zero immediately; fetch restarts at RESET_PC.
